// File: rtl/ped_pkg.sv
// rtl/ped_pkg.sv - shared lamp encodings and request-FSM state type
package ped_pkg;

   localparam logic [1:0] GREEN  = 2'd2;
   localparam logic [1:0] YELLOW = 2'd1;
   localparam logic [1:0] RED    = 2'd0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PENDING  = 2'd1,
      WALK     = 2'd2,
      COOLDOWN = 2'd3
   } ped_state_t;

endpackage

// File: rtl/ped_debounce.sv
// rtl/ped_debounce.sv - 2-flop synchronizer, level debounce and press pulse
module ped_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clock,
   input  logic clear_n,
   input  logic button_raw,
   output logic btn_db,
   output logic press
);

   localparam int            DW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] CNT_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          s1_q, s2_q;
   logic          btn_db_q, btn_db_d;
   logic [DW-1:0] cnt_q, cnt_d;
   logic          accept;

   always_comb begin
      btn_db_d = btn_db_q;
      cnt_d    = '0;
      accept   = 1'b0;
      if (s2_q != btn_db_q) begin
         if (cnt_q == CNT_LAST) begin
            accept   = 1'b1;
            btn_db_d = s2_q;
         end else begin
            cnt_d = cnt_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         btn_db_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         s1_q     <= button_raw;
         s2_q     <= s1_q;
         btn_db_q <= btn_db_d;
         cnt_q    <= cnt_d;
      end
   end

   // Pulse coincides with the edge that raises btn_db, so the FSM moves on that same edge.
   assign press  = accept & s2_q;
   assign btn_db = btn_db_q;

endmodule

// File: rtl/ped_request_ctrl.sv
// rtl/ped_request_ctrl.sv - pedestrian request latch, walk hold and cooldown
module ped_request_ctrl
   import ped_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int WALK_CYCLES     = 32,
   parameter int COOLDOWN_CYCLES = 64,
   parameter int CNT_W           = 8
) (
   input  logic       clock,
   input  logic       clear_n,
   input  logic       button_raw,
   input  logic [1:0] crossing,
   output logic       waiting,
   output logic       request_lamp,
   output logic [7:0] press_count
);

   localparam logic [CNT_W-1:0] WALK_LOAD = CNT_W'(WALK_CYCLES - 1);
   localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

   ped_state_t       state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic             pend_flag_q, pend_flag_d;
   logic [7:0]       press_count_q, press_count_d;
   logic             count_inc;
   logic             pend_now;
   logic             btn_db;
   logic             press;

   ped_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clock      (clock),
      .clear_n    (clear_n),
      .button_raw (button_raw),
      .btn_db     (btn_db),
      .press      (press)
   );

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      pend_flag_d = pend_flag_q;
      count_inc   = 1'b0;
      pend_now    = pend_flag_q;
      case (state_q)
         IDLE: begin
            if (press) begin
               state_d   = PENDING;
               count_inc = 1'b1;
            end
         end
         PENDING: begin
            if (crossing == GREEN) begin
               state_d = WALK;
               timer_d = WALK_LOAD;
            end
         end
         WALK: begin
            if (crossing != GREEN || timer_q == '0) begin
               state_d = COOLDOWN;
               timer_d = COOL_LOAD;
            end else begin
               timer_d = timer_q - CNT_W'(1);
            end
         end
         COOLDOWN: begin
            // Only the first press of a cooldown is queued and counted.
            if (press && !pend_flag_q) begin
               pend_now  = 1'b1;
               count_inc = 1'b1;
            end
            if (timer_q == '0) begin
               state_d     = pend_now ? PENDING : IDLE;
               pend_flag_d = 1'b0;
            end else begin
               timer_d     = timer_q - CNT_W'(1);
               pend_flag_d = pend_now;
            end
         end
         default: state_d = IDLE;
      endcase
      press_count_d = (count_inc && press_count_q != 8'hFF) ? press_count_q + 8'd1
                                                            : press_count_q;
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         pend_flag_q   <= 1'b0;
         press_count_q <= 8'd0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         pend_flag_q   <= pend_flag_d;
         press_count_q <= press_count_d;
      end
   end

   assign waiting      = (state_q == PENDING) || (state_q == WALK);
   assign request_lamp = (state_q == PENDING) || (state_q == COOLDOWN && pend_flag_q);
   assign press_count  = press_count_q;

   a_press_rising: assert property (@(posedge clock) disable iff (!clear_n) press |-> !btn_db);

endmodule
